// File: rtl/mips_debug_collector.sv
// Debug controller beside the pipelined MIPS core: gates the core clock-enable for run/step,
// counts enabled cycles, freezes a snapshot and streams it as a byte frame over valid/ready.
module mips_debug_collector #(
  parameter int unsigned         len_data        = 32,
  parameter int unsigned         num_regs        = 32,
  parameter int unsigned         num_latch_words = 4,
  parameter int unsigned         len_byte        = 8,
  parameter logic [len_byte-1:0] header_byte     = 8'hA5
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cmd_valid,
  input  logic [1:0]                          cmd,
  output logic                                cmd_ready,
  input  logic                                halt_flag,
  input  logic [len_data-1:0]                 in_pc,
  input  logic [num_latch_words*len_data-1:0] in_latches,
  input  logic [num_regs*len_data-1:0]        in_regs,
  output logic                                cpu_enable,
  output logic [len_byte-1:0]                 tx_data,
  output logic                                tx_valid,
  input  logic                                tx_ready,
  output logic                                busy,
  output logic [len_data-1:0]                 cycle_count
);

  localparam int unsigned NUM_WORDS = 2 + num_latch_words + num_regs;
  localparam int unsigned SHADOW_W  = NUM_WORDS * len_data;
  localparam int unsigned FRAME_LEN = 1 + SHADOW_W / len_byte;
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_DUMP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_CAPTURE,
    ST_SEND,
    ST_HALTED
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [len_data-1:0]   r_cycle_count;
  logic [SHADOW_W-1:0]   r_shadow;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_halt_end;
  logic                  w_xfer;
  logic                  w_last_xfer;

  assign w_xfer      = (r_state == ST_SEND) && tx_ready;
  assign w_last_xfer = w_xfer && (r_idx == LAST_IDX);
  assign cycle_count = r_cycle_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    cpu_enable   = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = '0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          case (cmd)
            CMD_RUN:  w_next_state = ST_RUN;
            CMD_STEP: w_next_state = halt_flag ? ST_CAPTURE : ST_STEP;
            CMD_DUMP: w_next_state = ST_CAPTURE;
            default:  w_next_state = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        cpu_enable = 1'b1;
        if (halt_flag) w_next_state = ST_CAPTURE;
      end
      ST_STEP: begin
        cpu_enable   = 1'b1;
        w_next_state = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_next_state = ST_SEND;
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        // Symbol 0 is the header; afterwards the shadow's low byte is always the next symbol.
        tx_data  = (r_idx == '0) ? header_byte : r_shadow[len_byte-1:0];
        if (w_last_xfer) w_next_state = r_halt_end ? ST_HALTED : ST_IDLE;
      end
      ST_HALTED: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid && (cmd == CMD_DUMP)) w_next_state = ST_CAPTURE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_count <= '0;
      r_shadow      <= '0;
      r_idx         <= '0;
      r_halt_end    <= 1'b0;
    end else begin
      if (cpu_enable) r_cycle_count <= r_cycle_count + len_data'(1);
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && (cmd != 2'b00)) r_halt_end <= 1'b0;
        end
        ST_RUN: begin
          if (halt_flag) r_halt_end <= 1'b1;
        end
        ST_CAPTURE: begin
          r_shadow   <= {in_regs, in_latches, in_pc, r_cycle_count};
          r_idx      <= '0;
          r_halt_end <= r_halt_end | halt_flag;
        end
        ST_SEND: begin
          if (w_xfer) begin
            r_idx <= w_last_xfer ? '0 : r_idx + IDX_W'(1);
            // Consuming a data byte exposes the next one; the header consumes nothing.
            if (r_idx != '0) r_shadow <= r_shadow >> len_byte;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_debug_collector.sv
// Randomised bench for mips_debug_collector: a per-cycle behavioural model plus directed
// literal checks on captured frames.
module tb_mips_debug_collector;

  localparam int LD = 32;
  localparam int NR = 32;
  localparam int NL = 4;
  localparam int LB = 8;
  localparam int FRAME_LEN = 1 + (2 + NL + NR) * LD / LB;
  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [1:0] C_RUN = 2'b01, C_STEP = 2'b10, C_DUMP = 2'b11;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic [1:0]      cmd;
  logic            cmd_ready;
  logic            halt_flag;
  logic [LD-1:0]   in_pc;
  logic [NL*LD-1:0] in_latches;
  logic [NR*LD-1:0] in_regs;
  logic            cpu_enable;
  logic [LB-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            busy;
  logic [LD-1:0]   cycle_count;

  mips_debug_collector #(
    .len_data(LD), .num_regs(NR), .num_latch_words(NL), .len_byte(LB), .header_byte(HDR)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .halt_flag(halt_flag), .in_pc(in_pc), .in_latches(in_latches), .in_regs(in_regs),
    .cpu_enable(cpu_enable), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_RUN, M_STEP, M_CAPTURE, M_SEND, M_HALTED} mPhase_t;

  int          tests = 0;
  int          errors = 0;
  logic [7:0]  rxQ[$];
  int          enCount = 0;
  bit          forceSync = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rxWord(input int idx);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) if (idx + b < rxQ.size()) w[8*b +: 8] = rxQ[idx + b];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick();
    cmd_valid = 1'b0;
    cmd       = 2'b00;
  endtask

  task automatic waitReady(input int budget);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("ready_within_budget", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic randomizeInputs();
    in_pc = $urandom();
    for (int w = 0; w < NL; w++) in_latches[w*LD +: LD] = $urandom();
    for (int w = 0; w < NR; w++) in_regs[w*LD +: LD] = $urandom();
  endtask

  // Behavioural model: the frame is a byte queue built from the words at capture time.
  task automatic modelLoop();
    mPhase_t     mPhase = M_IDLE;
    bit          mValid = 0;
    logic [31:0] mCount = '0;
    bit          mHaltEnd = 0;
    int          mPos = 0;
    logic [7:0]  mFrame[$];
    bit          prevStall = 0;
    logic [7:0]  prevData = '0;
    logic [31:0] word;
    bit          expReady;
    forever begin
      @(negedge clk);
      if (forceSync) mCount = '1;
      if (mValid) begin
        expReady = (mPhase == M_IDLE) || (mPhase == M_HALTED);
        checkOutput("cmd_ready", {31'd0, cmd_ready}, {31'd0, expReady});
        checkOutput("busy", {31'd0, busy}, {31'd0, !expReady});
        checkOutput("cpu_enable", {31'd0, cpu_enable}, {31'd0, (mPhase == M_RUN) || (mPhase == M_STEP)});
        checkOutput("tx_valid", {31'd0, tx_valid}, {31'd0, mPhase == M_SEND});
        checkOutput("cycle_count", cycle_count, mCount);
        if (mPhase == M_SEND) checkOutput("tx_data", {24'd0, tx_data}, {24'd0, mFrame[mPos]});
        if (prevStall) checkOutput("tx_data_hold", {24'd0, tx_data}, {24'd0, prevData});
      end
      prevStall = tx_valid && !tx_ready && !reset;
      prevData  = tx_data;
      if (tx_valid && tx_ready && !reset) rxQ.push_back(tx_data);
      if (cpu_enable && !reset) enCount++;
      if (reset) begin
        mValid = 1; mPhase = M_IDLE; mCount = '0; mPos = 0; mHaltEnd = 0;
      end else if (mValid) begin
        case (mPhase)
          M_IDLE: if (cmd_valid && cmd != 2'b00) begin
            mHaltEnd = 0;
            if (cmd == C_RUN) mPhase = M_RUN;
            else if (cmd == C_STEP) mPhase = halt_flag ? M_CAPTURE : M_STEP;
            else mPhase = M_CAPTURE;
          end
          M_RUN: begin
            mCount++;
            if (halt_flag) begin mPhase = M_CAPTURE; mHaltEnd = 1; end
          end
          M_STEP: begin mCount++; mPhase = M_CAPTURE; end
          M_CAPTURE: begin
            mFrame.delete();
            mFrame.push_back(HDR);
            for (int w = 0; w < 2 + NL + NR; w++) begin
              if (w == 0) word = mCount;
              else if (w == 1) word = in_pc;
              else if (w < 2 + NL) word = in_latches[(w-2)*LD +: LD];
              else word = in_regs[(w-2-NL)*LD +: LD];
              for (int b = 0; b < 4; b++) mFrame.push_back(word[8*b +: 8]);
            end
            mHaltEnd = mHaltEnd | halt_flag;
            mPos = 0;
            mPhase = M_SEND;
          end
          M_SEND: if (tx_ready) begin
            mPos++;
            if (mPos == FRAME_LEN) begin
              mPos = 0;
              mPhase = mHaltEnd ? M_HALTED : M_IDLE;
            end
          end
          M_HALTED: if (cmd_valid && cmd == C_DUMP) mPhase = M_CAPTURE;
          default: mPhase = M_IDLE;
        endcase
      end
    end
  endtask

  initial begin
    int base;
    int en0;
    int n;
    reset = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; halt_flag = 1'b0; tx_ready = 1'b1;
    in_pc = '0; in_latches = '0; in_regs = '0;
    fork
      modelLoop();
    join_none
    repeat (3) tick();
    checkOutput("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_cpu_enable", {31'd0, cpu_enable}, 32'd0);
    checkOutput("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("reset_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("reset_cycle_count", cycle_count, 32'd0);
    reset = 1'b0;
    tick();

    // Dump straight after reset with known PC and reg1.
    randomizeInputs();
    in_pc = 32'h0000_0040;
    in_regs[1*LD +: LD] = 32'h1234_5678;
    base = rxQ.size();
    applyStimulus(C_DUMP);
    waitReady(1000);
    checkOutput("dump_len", rxQ.size() - base, FRAME_LEN);
    checkOutput("dump_hdr", {24'd0, rxQ[base]}, 32'hA5);
    checkOutput("dump_count", rxWord(base + 1), 32'h0);
    checkOutput("dump_pc_bytes", rxWord(base + 5), 32'h0000_0040);
    checkOutput("dump_sym5", {24'd0, rxQ[base + 5]}, 32'h40);
    checkOutput("dump_sym29", {24'd0, rxQ[base + 29]}, 32'h78);
    checkOutput("dump_sym32", {24'd0, rxQ[base + 32]}, 32'h12);
    checkOutput("dump_reg1", rxWord(base + 29), 32'h1234_5678);

    // Three single steps.
    for (int i = 1; i <= 3; i++) begin
      randomizeInputs();
      base = rxQ.size();
      en0 = enCount;
      applyStimulus(C_STEP);
      checkOutput("step_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
      waitReady(1000);
      checkOutput("step_enable_cycles", enCount - en0, 32'd1);
      checkOutput("step_frame_count", rxWord(base + 1), i);
      checkOutput("step_len", rxQ.size() - base, FRAME_LEN);
    end

    // Counter wrap: preset the count to all ones, then step.
    force dut.r_cycle_count = 32'hFFFF_FFFF;
    forceSync = 1;
    tick();
    release dut.r_cycle_count;
    forceSync = 0;
    tick();
    base = rxQ.size();
    applyStimulus(C_STEP);
    waitReady(1000);
    checkOutput("wrap_frame_count", rxWord(base + 1), 32'h0);
    checkOutput("wrap_cycle_count", cycle_count, 32'h0);

    // Reset in the middle of a frame, then a full fresh dump.
    applyStimulus(C_STEP);
    waitReady(1000);
    base = rxQ.size();
    applyStimulus(C_DUMP);
    n = 0;
    while (rxQ.size() - base < 100 && n < 1000) begin tick(); n++; end
    checkOutput("midframe_reached", {31'd0, (rxQ.size() - base >= 100)}, 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("abort_cycle_count", cycle_count, 32'd0);
    checkOutput("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    reset = 1'b0;
    tick();
    base = rxQ.size();
    applyStimulus(C_DUMP);
    waitReady(1000);
    checkOutput("redump_len", rxQ.size() - base, FRAME_LEN);
    checkOutput("redump_hdr", {24'd0, rxQ[base]}, 32'hA5);

    // Random sink back-pressure, input churn during SEND and dropped commands.
    for (int it = 0; it < 6; it++) begin
      randomizeInputs();
      base = rxQ.size();
      applyStimulus((it % 2) ? C_STEP : C_DUMP);
      n = 0;
      while (cmd_ready !== 1'b1 && n < 4000) begin
        tx_ready = ($urandom_range(0, 99) < 30);
        if ($urandom_range(0, 3) == 0) randomizeInputs();
        if (rxQ.size() - base < FRAME_LEN - 20) begin
          cmd_valid = 1'($urandom_range(0, 1));
          cmd = 2'($urandom_range(0, 3));
        end else begin
          cmd_valid = 1'b0;
        end
        tick();
        n++;
      end
      cmd_valid = 1'b0;
      tx_ready = 1'b1;
      checkOutput("rand_done", {31'd0, cmd_ready}, 32'd1);
      checkOutput("rand_len", rxQ.size() - base, FRAME_LEN);
      tick();
    end

    // Run until halt on the tenth enabled cycle; ends HALTED.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    base = rxQ.size();
    en0 = enCount;
    applyStimulus(C_RUN);
    repeat (9) tick();
    halt_flag = 1'b1;
    waitReady(1000);
    checkOutput("run_enable_cycles", enCount - en0, 32'd10);
    checkOutput("run_frame_count", rxWord(base + 1), 32'd10);
    en0 = enCount;
    applyStimulus(C_STEP);
    tick();
    checkOutput("halted_step_ignored", enCount - en0, 32'd0);
    checkOutput("halted_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    base = rxQ.size();
    applyStimulus(C_DUMP);
    waitReady(1000);
    checkOutput("halted_dump_count", rxWord(base + 1), 32'd10);
    checkOutput("halted_dump_len", rxQ.size() - base, FRAME_LEN);
    applyStimulus(C_RUN);
    tick();
    checkOutput("halted_run_ignored", {31'd0, cpu_enable}, 32'd0);
    checkOutput("halted_busy", {31'd0, busy}, 32'd0);
    halt_flag = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
